// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction fetch stage. Holds the program counter and presents it to a
// combinational instruction ROM. Each cycle, the returned word and its PC
// are captured into the IF/ID register for decode. Decode can stall the
// stage. A branch or jump redirect flushes the slot and loads a new PC.
// The stage also keeps a saturating count of issued words.
//
// Parameters
//   RESET_PC  : PC loaded on reset
//   NOP_WORD  : bubble word placed in IF/ID on reset and on flush
//
// Ports
//   clk            in   clock, rising-edge active
//   rst_n          in   synchronous active-low reset
//   stall          in   decode cannot accept; hold PC and IF/ID
//   redirect_valid in   taken branch/jump; flush slot, load redirect_addr
//   redirect_addr  in   [7:0]  target PC
//   rom_addr       out  [7:0]  ROM address (the PC register)
//   rom_data       in   [15:0] ROM word for rom_addr, same cycle
//   if_id_instr    out  [15:0] registered instruction
//   if_id_pc       out  [7:0]  registered PC of if_id_instr
//   if_id_valid    out  if_id_instr is a fetched word, not a bubble
//   fetch_count    out  [15:0] words issued, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter logic [7:0]  RESET_PC = 8'd0,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_addr,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] if_id_instr,
  output logic [7:0]  if_id_pc,
  output logic        if_id_valid,
  output logic [15:0] fetch_count
);

  logic [7:0]  pc_q,    pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  ipc_q,   ipc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  // Priority below reset: a redirect overrides a stall, and a stall
  // overrides a normal fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    count_d = count_q;
    if (redirect_valid) begin
      // The word being fetched this cycle is from the wrong path, so drop it.
      // if_id_pc keeps its previous value.
      pc_d    = redirect_addr;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = rom_data;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + 8'd1;  // wraps FF -> 00 naturally
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      ipc_q   <= 8'd0;
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_valid = valid_q;
  assign fetch_count = count_q;

endmodule
